md_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that sits beside the combinational ALU in the execute stage. It performs signed and unsigned multiply, multiply-accumulate and divide into dedicated HI/LO registers, and supports direct HI/LO writes. A fixed, parameter-set busy window lets the pipeline controller stall dependent instructions without knowing the datapath internals.

---
 rtl/md_unit.sv | 156 +++++++++++++++
 tb/tb_md_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply / multiply-accumulate / divide unit writing HI/LO.
// The busy window is a fixed per-class latency so the pipeline can stall blindly.
module md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic                    div_zero, div_ovf;
    logic [WIDTH-1:0]        div_b;
    logic signed [WIDTH-1:0] quo_s, rem_s;
    logic [WIDTH-1:0]        quo_u, rem_u;
    logic [2*WIDTH-1:0]      prod_s, prod_u, result;

    // Result datapath works only on the operands latched at start.
    always_comb begin
        div_zero = (b_q == '0);
        div_ovf  = (a_q == MOST_NEG) && (b_q == ALL_ONES);
        // Zero and overflow cases are overridden below; a safe divisor keeps the divider defined.
        div_b    = (div_zero || div_ovf) ? ONE : b_q;
        quo_s    = $signed(a_q) / $signed(div_b);
        rem_s    = $signed(a_q) % $signed(div_b);
        quo_u    = a_q / div_b;
        rem_u    = a_q % div_b;
        prod_s   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

        result = {hi_q, lo_q};
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_MADD:  result = {hi_q, lo_q} + prod_s;
            OP_DIV: begin
                if (div_zero)     result = {a_q, ALL_ONES};
                else if (div_ovf) result = {{WIDTH{1'b0}}, a_q};
                else              result = {rem_s, quo_s};
            end
            OP_DIVU: begin
                if (div_zero) result = {a_q, ALL_ONES};
                else          result = {rem_u, quo_u};
            end
            default:  result = {hi_q, lo_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_MADD: begin
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = MUL_CNT;
                            state_d = ST_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = DIV_CNT;
                            state_d = ST_BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // Flush abandons the operation without touching HI/LO.
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q <= CNT_ONE) begin
                    cnt_d         = '0;
                    {hi_d, lo_d}  = result;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected {hi,lo} are queued at issue and popped at completion.
module tb_md_unit;
    localparam int W       = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;

    logic         clk = 1'b0;
    logic         reset_n, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    md_unit #(.WIDTH(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse, then scrambles operands to prove they were latched.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat);
        issue(o, x, y);
        wait_idle(lat);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++;
        if ({hi, lo} !== '0) begin errors++; $display("[TB] FAIL reset_hilo got %h want 0", {hi, lo}); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic [2:0]   ops [2] = '{OP_MULT, OP_MULTU};
        logic [2*W-1:0] exps [2] = '{64'hFFFFFFFF_FFFFFFFA, 64'h00000002_FFFFFFFA};
        logic [2*W-1:0] expv;
        int lat;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exps[i]);
            run_op(ops[i], 32'hFFFFFFFE, 32'd3, lat);
            checks++;
            if (lat != MUL_LAT) begin errors++; $display("[TB] FAIL mult_lat[%0d] got %0d want %0d", i, lat, MUL_LAT); end
            expv = exp_q.pop_front();
            checks++;
            if ({hi, lo} !== expv) begin errors++; $display("[TB] FAIL mult[%0d] got %h want %h", i, {hi, lo}, expv); end
        end
    endtask

    task automatic test_div();
        logic [2:0]     ops [4] = '{OP_DIVU, OP_DIV, OP_DIVU, OP_DIV};
        logic [W-1:0]   xs  [4] = '{32'd100, 32'hFFFFFFF9, 32'h12345678, 32'h80000000};
        logic [W-1:0]   ys  [4] = '{32'd7, 32'd2, 32'd0, 32'hFFFFFFFF};
        logic [2*W-1:0] exps [4] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD},
                                     {32'h12345678, 32'hFFFFFFFF}, {32'h0, 32'h80000000}};
        logic [2*W-1:0] expv;
        int lat;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            run_op(ops[i], xs[i], ys[i], lat);
            checks++;
            if (lat != DIV_LAT) begin errors++; $display("[TB] FAIL div_lat[%0d] got %0d want %0d", i, lat, DIV_LAT); end
            expv = exp_q.pop_front();
            checks++;
            if ({hi, lo} !== expv) begin errors++; $display("[TB] FAIL div[%0d] got %h want %h", i, {hi, lo}, expv); end
        end
    endtask

    task automatic test_mthi_madd();
        logic [2*W-1:0] expv;
        int lat;
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'd10, 32'd0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mt_busy got %b want 0", busy); end
        checks++;
        if ({hi, lo} !== {32'd0, 32'd10}) begin errors++; $display("[TB] FAIL mt_hilo got %h want %h", {hi, lo}, {32'd0, 32'd10}); end
        exp_q.push_back({32'd0, 32'd22});
        run_op(OP_MADD, 32'd3, 32'd4, lat);
        expv = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== expv) begin errors++; $display("[TB] FAIL madd1 got %h want %h", {hi, lo}, expv); end
        exp_q.push_back({32'd0, 32'd21});
        run_op(OP_MADD, 32'hFFFFFFFF, 32'd1, lat);
        expv = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== expv) begin errors++; $display("[TB] FAIL madd2 got %h want %h", {hi, lo}, expv); end
    endtask

    task automatic test_ignore_start();
        logic [2*W-1:0] expv;
        int rest;
        exp_q.push_back({32'd0, 32'd10});
        issue(OP_DIV, 32'd50, 32'd5);
        repeat (2) tick();
        op = OP_MULT; a = 32'd7; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ignore_busy got %b want 1", busy); end
        wait_idle(rest);
        checks++;
        if (rest + 3 != DIV_LAT) begin errors++; $display("[TB] FAIL ignore_lat got %0d want %0d", rest + 3, DIV_LAT); end
        expv = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== expv) begin errors++; $display("[TB] FAIL ignore_result got %h want %h", {hi, lo}, expv); end
    endtask

    task automatic test_flush();
        issue(OP_DIV, 32'd9, 32'd2);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %b want 0", busy); end
        repeat (12) tick();
        checks++;
        if ({hi, lo} !== {32'd0, 32'd10}) begin errors++; $display("[TB] FAIL flush_hilo got %h want %h", {hi, lo}, {32'd0, 32'd10}); end
        op = OP_MTLO; a = 32'd99; start = 1'b1; flush = 1'b1;
        tick();
        checks++;
        if (lo !== 32'd10) begin errors++; $display("[TB] FAIL flush_mtlo got %h want %h", lo, 32'd10); end
        op = OP_MULT; a = 32'd3; b = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_start got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] expv;
        int lat;
        issue(OP_MULT, 32'd5, 32'd5);
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, hi, lo} !== '0) begin errors++; $display("[TB] FAIL midreset got busy=%b hilo=%h want 0", busy, {hi, lo}); end
        tick();
        reset_n = 1'b1;
        tick();
        exp_q.push_back({32'd0, 32'd6});
        run_op(OP_MULT, 32'd2, 32'd3, lat);
        expv = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== expv) begin errors++; $display("[TB] FAIL after_reset got %h want %h", {hi, lo}, expv); end
    endtask

    task automatic test_random();
        logic [2:0]          o;
        logic [W-1:0]        x, y;
        logic signed [63:0]  sx, sy;
        logic [2*W-1:0]      expv;
        int lat;
        for (int i = 0; i < 6; i++) begin
            x = $urandom; y = $urandom_range(1, 1000);
            o = (i % 3 == 0) ? OP_MULT : (i % 3 == 1) ? OP_MULTU : OP_DIVU;
            sx = $signed(x); sy = $signed(y);
            if (o == OP_MULT)       exp_q.push_back(sx * sy);
            else if (o == OP_MULTU) exp_q.push_back({32'd0, x} * {32'd0, y});
            else                    exp_q.push_back({x % y, x / y});
            run_op(o, x, y, lat);
            expv = exp_q.pop_front();
            checks++;
            if ({hi, lo} !== expv) begin errors++; $display("[TB] FAIL random[%0d] op=%0d got %h want %h", i, o, {hi, lo}, expv); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_madd();
        test_ignore_start();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
